// File: rtl/magnet_cmd_sequencer_if.sv
// Button inputs and driver command/status outputs of the electromagnet sequencer.
// No flow control: buttons are raw levels and the outputs are registered status.
interface magnet_cmd_sequencer_if;
    logic       i_grab_btn;
    logic       i_drop_btn;
    logic [1:0] o_mag_cmd;
    logic       o_busy;
    logic       o_holding;
    logic [1:0] o_state_out;

    modport master (
        output i_grab_btn,
        output i_drop_btn,
        input  o_mag_cmd,
        input  o_busy,
        input  o_holding,
        input  o_state_out
    );

    modport slave (
        input  i_grab_btn,
        input  i_drop_btn,
        output o_mag_cmd,
        output o_busy,
        output o_holding,
        output o_state_out
    );
endinterface

// File: rtl/magnet_cmd_sequencer.sv
// Debounced grab/drop buttons drive a HOLD/RELEASE/COOLDOWN magnet sequencer.
// Press-to-command latency is DEBOUNCE_CYCLES+3 edges; no backpressure, extra presses are dropped.
module magnet_cmd_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned RELEASE_CYCLES  = 50000000,
    parameter int unsigned COOLDOWN_CYCLES = 25000000,
    parameter int unsigned HOLD_TIMEOUT    = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    magnet_cmd_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HOLD     = 2'd1,
        S_RELEASE  = 2'd2,
        S_COOLDOWN = 2'd3
    } state_t;

    localparam logic [31:0] DB_LAST   = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] REL_LAST  = 32'(RELEASE_CYCLES - 1);
    localparam logic [31:0] COOL_LAST = 32'(COOLDOWN_CYCLES - 1);
    localparam logic [31:0] HOLD_LAST = 32'(HOLD_TIMEOUT - 1);
    localparam bit          HOLD_EN   = (HOLD_TIMEOUT != 0);

    // Index 0 is grab, index 1 is drop.
    logic [1:0]  w_raw;
    logic [1:0]  r_sync1;
    logic [1:0]  r_sync2;
    logic [1:0]  r_db_level;
    logic [1:0]  r_db_level_q;
    logic [31:0] r_db_cnt [2];
    logic        w_grab_req;
    logic        w_drop_req;

    state_t      r_state;
    logic [31:0] r_phase_cnt;
    logic [31:0] r_hold_cnt;
    logic [1:0]  r_mag_cmd;
    logic        r_busy;
    logic        r_holding;

    assign w_raw = {bus.i_drop_btn, bus.i_grab_btn};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_db_level   <= '0;
            r_db_level_q <= '0;
            for (int b = 0; b < 2; b++) begin
                r_db_cnt[b] <= '0;
            end
        end else begin
            r_sync1      <= w_raw;
            r_sync2      <= r_sync1;
            r_db_level_q <= r_db_level;
            for (int b = 0; b < 2; b++) begin
                if (r_sync2[b] != r_db_level[b]) begin
                    if (r_db_cnt[b] == DB_LAST) begin
                        r_db_level[b] <= r_sync2[b];
                        r_db_cnt[b]   <= '0;
                    end else begin
                        r_db_cnt[b] <= r_db_cnt[b] + 32'd1;
                    end
                end else begin
                    r_db_cnt[b] <= '0;
                end
            end
        end
    end

    // Rising edge of the debounced level: one pulse per accepted press.
    assign w_grab_req = r_db_level[0] & ~r_db_level_q[0];
    assign w_drop_req = r_db_level[1] & ~r_db_level_q[1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_phase_cnt <= '0;
            r_hold_cnt  <= '0;
            r_mag_cmd   <= 2'b00;
            r_busy      <= 1'b0;
            r_holding   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grab_req && !w_drop_req) begin
                        r_state     <= S_HOLD;
                        r_phase_cnt <= '0;
                        r_hold_cnt  <= '0;
                        r_mag_cmd   <= 2'b01;
                        r_busy      <= 1'b1;
                        r_holding   <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_drop_req || (HOLD_EN && r_hold_cnt == HOLD_LAST)) begin
                        r_state     <= S_RELEASE;
                        r_phase_cnt <= '0;
                        r_mag_cmd   <= 2'b10;
                        r_busy      <= 1'b1;
                        r_holding   <= 1'b0;
                    end else if (HOLD_EN) begin
                        r_hold_cnt <= r_hold_cnt + 32'd1;
                    end
                end
                S_RELEASE: begin
                    if (r_phase_cnt == REL_LAST) begin
                        r_state     <= S_COOLDOWN;
                        r_phase_cnt <= '0;
                        r_mag_cmd   <= 2'b00;
                        r_busy      <= 1'b1;
                        r_holding   <= 1'b0;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + 32'd1;
                    end
                end
                S_COOLDOWN: begin
                    // Presses arriving here are discarded, not queued.
                    if (r_phase_cnt == COOL_LAST) begin
                        r_state     <= S_IDLE;
                        r_phase_cnt <= '0;
                        r_mag_cmd   <= 2'b00;
                        r_busy      <= 1'b0;
                        r_holding   <= 1'b0;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + 32'd1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_phase_cnt <= '0;
                    r_mag_cmd   <= 2'b00;
                    r_busy      <= 1'b0;
                    r_holding   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_mag_cmd   = r_mag_cmd;
    assign bus.o_busy      = r_busy;
    assign bus.o_holding   = r_holding;
    assign bus.o_state_out = r_state;

endmodule

// File: tb/tb_magnet_cmd_sequencer.sv
// Directed bench for magnet_cmd_sequencer: one DUT with hold timeout disabled, one with 50.
module tb_magnet_cmd_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_viol   = 0;

    // Observed vector: {mag_cmd, busy, holding, state_out}
    localparam logic [5:0] IDLE_V = 6'b00_0_0_00;
    localparam logic [5:0] HOLD_V = 6'b01_1_1_01;
    localparam logic [5:0] REL_V  = 6'b10_1_0_10;
    localparam logic [5:0] COOL_V = 6'b00_1_0_11;

    magnet_cmd_sequencer_if if1 ();
    magnet_cmd_sequencer_if if2 ();

    magnet_cmd_sequencer #(
        .DEBOUNCE_CYCLES(4), .RELEASE_CYCLES(20), .COOLDOWN_CYCLES(8), .HOLD_TIMEOUT(0)
    ) u_dut1 (
        .i_clk(clk), .i_rst(rst), .bus(if1)
    );

    magnet_cmd_sequencer #(
        .DEBOUNCE_CYCLES(4), .RELEASE_CYCLES(20), .COOLDOWN_CYCLES(8), .HOLD_TIMEOUT(50)
    ) u_dut2 (
        .i_clk(clk), .i_rst(rst), .bus(if2)
    );

    logic [5:0] obs1;
    logic [5:0] obs2;
    assign obs1 = {if1.o_mag_cmd, if1.o_busy, if1.o_holding, if1.o_state_out};
    assign obs2 = {if2.o_mag_cmd, if2.o_busy, if2.o_holding, if2.o_state_out};

    always #5 clk = ~clk;

    // Illegal command values or a direct 01->00 step outside reset.
    logic [1:0] prev1 = 2'b00;
    logic [1:0] prev2 = 2'b00;
    always @(negedge clk) begin
        if (rst) begin
            prev1 = 2'b00;
            prev2 = 2'b00;
        end else begin
            if (if1.o_mag_cmd == 2'b11 || (prev1 == 2'b01 && if1.o_mag_cmd == 2'b00)) n_viol++;
            if (if2.o_mag_cmd == 2'b11 || (prev2 == 2'b01 && if2.o_mag_cmd == 2'b00)) n_viol++;
            prev1 = if1.o_mag_cmd;
            prev2 = if2.o_mag_cmd;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if1.i_grab_btn = 1'b0; if1.i_drop_btn = 1'b0;
        if2.i_grab_btn = 1'b0; if2.i_drop_btn = 1'b0;
        tick(3);
        n_checks++;
        if (obs1 !== IDLE_V) begin n_fail++; $display("FAIL reset_dut1: got %b want %b", obs1, IDLE_V); end
        n_checks++;
        if (obs2 !== IDLE_V) begin n_fail++; $display("FAIL reset_dut2: got %b want %b", obs2, IDLE_V); end
        rst = 1'b0;
        tick(5);
        n_checks++;
        if (obs1 !== IDLE_V) begin n_fail++; $display("FAIL reset_idle_after: got %b want %b", obs1, IDLE_V); end
    endtask

    task automatic test_glitch_and_grab();
        if1.i_grab_btn = 1'b1;
        tick(3);
        if1.i_grab_btn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            n_checks++;
            if (obs1 !== IDLE_V) begin n_fail++; $display("FAIL glitch_idle[%0d]: got %b want %b", i, obs1, IDLE_V); end
        end
        if1.i_grab_btn = 1'b1;
        tick(6);
        n_checks++;
        if (obs1 !== IDLE_V) begin n_fail++; $display("FAIL grab_edge6: got %b want %b", obs1, IDLE_V); end
        tick(1);
        n_checks++;
        if (obs1 !== HOLD_V) begin n_fail++; $display("FAIL grab_edge7: got %b want %b", obs1, HOLD_V); end
    endtask

    task automatic test_release();
        if1.i_grab_btn = 1'b0;
        tick(10);
        n_checks++;
        if (obs1 !== HOLD_V) begin n_fail++; $display("FAIL hold_no_timeout: got %b want %b", obs1, HOLD_V); end
        if1.i_drop_btn = 1'b1;
        tick(6);
        n_checks++;
        if (obs1 !== HOLD_V) begin n_fail++; $display("FAIL drop_edge6: got %b want %b", obs1, HOLD_V); end
        tick(1);
        n_checks++;
        if (obs1 !== REL_V) begin n_fail++; $display("FAIL drop_edge7: got %b want %b", obs1, REL_V); end
        for (int i = 1; i < 20; i++) begin
            tick(1);
            n_checks++;
            if (obs1 !== REL_V) begin n_fail++; $display("FAIL release_cyc[%0d]: got %b want %b", i, obs1, REL_V); end
        end
        tick(1);
        n_checks++;
        if (obs1 !== COOL_V) begin n_fail++; $display("FAIL cooldown_entry: got %b want %b", obs1, COOL_V); end
        for (int i = 1; i < 8; i++) begin
            tick(1);
            n_checks++;
            if (obs1 !== COOL_V) begin n_fail++; $display("FAIL cooldown_cyc[%0d]: got %b want %b", i, obs1, COOL_V); end
        end
        tick(1);
        n_checks++;
        if (obs1 !== IDLE_V) begin n_fail++; $display("FAIL cooldown_exit: got %b want %b", obs1, IDLE_V); end
        if1.i_drop_btn = 1'b0;
        tick(10);
        n_checks++;
        if (obs1 !== IDLE_V) begin n_fail++; $display("FAIL drop_release_idle: got %b want %b", obs1, IDLE_V); end
    endtask

    task automatic test_same_cycle();
        if1.i_grab_btn = 1'b1; if1.i_drop_btn = 1'b1;
        tick(7);
        n_checks++;
        if (obs1 !== IDLE_V) begin n_fail++; $display("FAIL both_idle_edge7: got %b want %b", obs1, IDLE_V); end
        tick(5);
        n_checks++;
        if (obs1 !== IDLE_V) begin n_fail++; $display("FAIL both_idle_later: got %b want %b", obs1, IDLE_V); end
        if1.i_grab_btn = 1'b0; if1.i_drop_btn = 1'b0;
        tick(10);
        if1.i_grab_btn = 1'b1;
        tick(7);
        n_checks++;
        if (obs1 !== HOLD_V) begin n_fail++; $display("FAIL grab_again: got %b want %b", obs1, HOLD_V); end
        if1.i_grab_btn = 1'b0;
        tick(10);
        if1.i_grab_btn = 1'b1; if1.i_drop_btn = 1'b1;
        tick(7);
        n_checks++;
        if (obs1 !== REL_V) begin n_fail++; $display("FAIL both_in_hold: got %b want %b", obs1, REL_V); end
        if1.i_grab_btn = 1'b0; if1.i_drop_btn = 1'b0;
        tick(17);
        if1.i_grab_btn = 1'b1;
        tick(3);
        n_checks++;
        if (obs1 !== COOL_V) begin n_fail++; $display("FAIL cool_grab_entry: got %b want %b", obs1, COOL_V); end
        tick(8);
        n_checks++;
        if (obs1 !== IDLE_V) begin n_fail++; $display("FAIL cool_grab_idle: got %b want %b", obs1, IDLE_V); end
        tick(10);
        n_checks++;
        if (obs1 !== IDLE_V) begin n_fail++; $display("FAIL cool_grab_discarded: got %b want %b", obs1, IDLE_V); end
        if1.i_grab_btn = 1'b0;
        tick(10);
    endtask

    task automatic test_hold_timeout();
        if2.i_grab_btn = 1'b1;
        tick(7);
        n_checks++;
        if (obs2 !== HOLD_V) begin n_fail++; $display("FAIL to_hold_entry: got %b want %b", obs2, HOLD_V); end
        tick(49);
        n_checks++;
        if (obs2 !== HOLD_V) begin n_fail++; $display("FAIL to_hold_49: got %b want %b", obs2, HOLD_V); end
        tick(1);
        n_checks++;
        if (obs2 !== REL_V) begin n_fail++; $display("FAIL to_release_50: got %b want %b", obs2, REL_V); end
        tick(19);
        n_checks++;
        if (obs2 !== REL_V) begin n_fail++; $display("FAIL to_release_last: got %b want %b", obs2, REL_V); end
        tick(1);
        n_checks++;
        if (obs2 !== COOL_V) begin n_fail++; $display("FAIL to_cooldown: got %b want %b", obs2, COOL_V); end
        tick(7);
        n_checks++;
        if (obs2 !== COOL_V) begin n_fail++; $display("FAIL to_cooldown_last: got %b want %b", obs2, COOL_V); end
        tick(1);
        n_checks++;
        if (obs2 !== IDLE_V) begin n_fail++; $display("FAIL to_idle: got %b want %b", obs2, IDLE_V); end
        if2.i_grab_btn = 1'b0;
        tick(10);
        n_checks++;
        if (obs2 !== IDLE_V) begin n_fail++; $display("FAIL to_stays_idle: got %b want %b", obs2, IDLE_V); end
    endtask

    task automatic test_reset_mid_release();
        if1.i_grab_btn = 1'b1;
        tick(7);
        n_checks++;
        if (obs1 !== HOLD_V) begin n_fail++; $display("FAIL mid_hold: got %b want %b", obs1, HOLD_V); end
        if1.i_grab_btn = 1'b0; if1.i_drop_btn = 1'b1;
        tick(7);
        n_checks++;
        if (obs1 !== REL_V) begin n_fail++; $display("FAIL mid_release_entry: got %b want %b", obs1, REL_V); end
        tick(10);
        n_checks++;
        if (obs1 !== REL_V) begin n_fail++; $display("FAIL mid_release_10: got %b want %b", obs1, REL_V); end
        rst = 1'b1;
        if1.i_drop_btn = 1'b0;
        #1;
        n_checks++;
        if (obs1 !== IDLE_V) begin n_fail++; $display("FAIL async_reset: got %b want %b", obs1, IDLE_V); end
        tick(2);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(5);
            n_checks++;
            if (obs1 !== IDLE_V) begin n_fail++; $display("FAIL post_reset_idle[%0d]: got %b want %b", i, obs1, IDLE_V); end
        end
    endtask

    initial begin
        test_reset();
        test_glitch_and_grab();
        test_release();
        test_same_cycle();
        test_hold_timeout();
        test_reset_mid_release();
        n_checks++;
        if (n_viol !== 0) begin n_fail++; $display("FAIL cmd_sequence_rules: got %0d violations want 0", n_viol); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
